// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit
// Brief    : Fetch-PC owner for a 3-stage F/D/X MIPS pipeline. Predecodes
//            jumps and BHT-predicted branches in D, resolves branches and JR
//            in X, repairs mispredicts and counts X-stage redirects.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             d_valid,
    input  logic [31:0]      d_pc,
    input  logic [31:0]      d_instr,
    input  logic             x_br_valid,
    input  logic [2:0]       x_br_type,
    input  logic [31:0]      x_pc,
    input  logic [15:0]      x_offset,
    input  logic [31:0]      x_rega,
    input  logic [31:0]      x_regb,
    input  logic             x_pred_taken,
    output logic [31:0]      pc_f,
    output logic             pred_taken_d,
    output logic             kill_f,
    output logic             kill_d,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] c_BEQ  = 3'd0;
    localparam logic [2:0] c_BNE  = 3'd1;
    localparam logic [2:0] c_BLEZ = 3'd2;
    localparam logic [2:0] c_BGTZ = 3'd3;
    localparam logic [2:0] c_BLTZ = 3'd4;
    localparam logic [2:0] c_BGEZ = 3'd5;
    localparam logic [2:0] c_JR   = 3'd6;

    logic [31:0]      r_pcF;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_bht [BHT_ENTRIES];

    // ---------------- D-stage predecode ----------------
    logic [5:0]       w_op;
    logic [4:0]       w_rt;
    logic             w_dIsJump;
    logic             w_dIsCond;
    logic [IDX_W-1:0] w_dIdx;
    logic             w_dPredTaken;
    logic [31:0]      w_dBrOff;
    logic [31:0]      w_dTarget;
    logic             w_dRedirect;

    assign w_op      = d_instr[31:26];
    assign w_rt      = d_instr[20:16];
    assign w_dIsJump = d_valid && (w_op == 6'h02 || w_op == 6'h03);
    assign w_dIsCond = d_valid && ((w_op >= 6'h04 && w_op <= 6'h07) ||
                                   (w_op == 6'h01 && (w_rt == 5'h00 || w_rt == 5'h01)));
    assign w_dIdx    = d_pc[IDX_W+1:2];
    // Lookup sees the counter as it stood before any same-cycle X update.
    assign w_dPredTaken = !rst && w_dIsCond && r_bht[w_dIdx][1];
    assign w_dBrOff     = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
    assign w_dTarget    = w_dIsJump ? {d_pc[31:28], d_instr[25:0], 2'b00}
                                    : d_pc + 32'd4 + w_dBrOff;
    assign w_dRedirect  = w_dIsJump || w_dPredTaken;

    // ---------------- X-stage resolve ----------------
    logic        w_xTaken;
    logic        w_xIsCond;
    logic        w_xIsJr;
    logic        w_xMispredict;
    logic        w_xRedirect;
    logic [31:0] w_xPcPlus4;
    logic [31:0] w_xFixPc;
    logic        w_bhtWrite;
    logic [IDX_W-1:0] w_xIdx;

    always_comb begin
        w_xTaken = 1'b0;
        case (x_br_type)
            c_BEQ:   w_xTaken = (x_rega == x_regb);
            c_BNE:   w_xTaken = (x_rega != x_regb);
            c_BLEZ:  w_xTaken = ($signed(x_rega) <= 32'sd0);
            c_BGTZ:  w_xTaken = ($signed(x_rega) >  32'sd0);
            c_BLTZ:  w_xTaken = ($signed(x_rega) <  32'sd0);
            c_BGEZ:  w_xTaken = ($signed(x_rega) >= 32'sd0);
            default: w_xTaken = 1'b0;
        endcase
    end

    assign w_xIsCond     = x_br_valid && (x_br_type <= c_BGEZ);
    assign w_xIsJr       = x_br_valid && (x_br_type == c_JR);
    assign w_xMispredict = w_xIsCond && (w_xTaken != x_pred_taken);
    assign w_xRedirect   = w_xMispredict || w_xIsJr;
    assign w_xPcPlus4    = x_pc + 32'd4;
    assign w_xFixPc      = w_xIsJr   ? x_rega :
                           w_xTaken  ? w_xPcPlus4 + {{14{x_offset[15]}}, x_offset, 2'b00}
                                     : w_xPcPlus4;
    assign w_bhtWrite    = w_xIsCond && !stall && !rst;
    assign w_xIdx        = x_pc[IDX_W+1:2];

    // ---------------- Next-PC selection ----------------
    logic [31:0] w_pcNext;

    always_comb begin
        w_pcNext = r_pcF + 32'd4;
        if (rst)
            w_pcNext = RESET_PC;
        else if (stall)
            w_pcNext = r_pcF;
        else if (w_xRedirect)
            w_pcNext = w_xFixPc;
        else if (w_dRedirect)
            w_pcNext = w_dTarget;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcF   <= RESET_PC;
            r_count <= '0;
        end else begin
            r_pcF <= w_pcNext;
            if (!stall && w_xRedirect)
                r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                r_bht[i] <= 2'b01;
        end else if (w_bhtWrite) begin
            if (w_xTaken && r_bht[w_xIdx] != 2'b11)
                r_bht[w_xIdx] <= r_bht[w_xIdx] + 2'b01;
            else if (!w_xTaken && r_bht[w_xIdx] != 2'b00)
                r_bht[w_xIdx] <= r_bht[w_xIdx] - 2'b01;
        end
    end

    assign pc_f             = r_pcF;
    assign mispredict_count = r_count;
    assign pred_taken_d     = w_dPredTaken;
    assign kill_f           = rst || (!stall && (w_xRedirect || w_dRedirect));
    assign kill_d           = rst || (!stall && w_xRedirect);

endmodule
`default_nettype wire
